// File: rtl/pwm_capture_pkg.sv
// pwm_capture shared definitions: register map, bit positions, FSM states.
// Imported by the PWM measurement slave and its bus interface users.
package pwm_capture_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_HIGH   = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;
    localparam int CTRL_IRQ_BIT = 2;

    localparam int STAT_VALID_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;
    localparam int STAT_LEVEL_BIT = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH_PH   = 2'd2,
        LOW_PH    = 2'd3
    } capState_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Chipselect/read/write register bus shared with the PWM generator wrapper.
// master drives strobes, address and write data; slave returns read data.
interface pwm_capture_if;

    logic        iChipselect_n;
    logic        iWrite_n;
    logic        iRead_n;
    logic [1:0]  iAddress;
    logic [31:0] iData;
    logic [31:0] oData;

    modport master (
        output iChipselect_n,
        output iWrite_n,
        output iRead_n,
        output iAddress,
        output iData,
        input  oData
    );

    modport slave (
        input  iChipselect_n,
        input  iWrite_n,
        input  iRead_n,
        input  iAddress,
        input  iData,
        output oData
    );

endinterface

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous line plus rise/fall pulses.
// Pulses are one cycle wide and derived from the synchronized level.
module pwm_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic iClk,
    input  logic iReset_n,
    input  logic iAsync,
    output logic oLevel,
    output logic oRise,
    output logic oFall
);

    logic [STAGES-1:0] syncQ;
    logic              prevQ;

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            syncQ <= '0;
            prevQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[STAGES-2:0], iAsync};
            prevQ <= syncQ[STAGES-1];
        end
    end

    assign oLevel = syncQ[STAGES-1];
    assign oRise  = syncQ[STAGES-1] & ~prevQ;
    assign oFall  = ~syncQ[STAGES-1] & prevQ;

endmodule

// File: rtl/pwm_capture.sv
// Memory-mapped PWM period/high-time measurement slave.
// Define PWM_CAPTURE_IRQ_EN to add CTRL.irq_en and the oIrq output.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk,
    input  logic iReset_n,
    pwm_capture_if.slave bus,
    input  logic iPwm
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    output logic oIrq
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic pwmLevel;
    logic pwmRise;
    logic pwmFall;

    capState_t state;
    capState_t stateNext;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcntNext;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;

    logic ctrlEn;
    logic statValid;
    logic statOvf;

    logic wrEn;
    logic rdEn;
    logic ctrlWr;
    logic enNext;
    logic clearReq;
    logic w1cValid;
    logic w1cOvf;
    logic capture;
    logic ovfSet;

    logic [31:0] rdData;
    logic        ctrlIrqEn;
    logic        unusedData;

    pwm_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iAsync   (iPwm),
        .oLevel   (pwmLevel),
        .oRise    (pwmRise),
        .oFall    (pwmFall)
    );

    assign wrEn = !bus.iChipselect_n && !bus.iWrite_n;
    assign rdEn = !bus.iChipselect_n && !bus.iRead_n
                  && bus.iWrite_n;

    assign ctrlWr   = wrEn && (bus.iAddress == ADDR_CTRL);
    assign enNext   = ctrlWr ? bus.iData[CTRL_EN_BIT] : ctrlEn;
    assign clearReq = ctrlWr && bus.iData[CTRL_CLR_BIT];
    assign w1cValid = wrEn && (bus.iAddress == ADDR_STATUS)
                      && bus.iData[STAT_VALID_BIT];
    assign w1cOvf   = wrEn && (bus.iAddress == ADDR_STATUS)
                      && bus.iData[STAT_OVF_BIT];

    assign unusedData = &{1'b0, bus.iData};

    // Saturation is checked before edges so cnt never wraps into a result
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        hcntNext  = hcnt;
        capture   = 1'b0;
        ovfSet    = 1'b0;
        unique case (state)
            IDLE: begin
                cntNext  = '0;
                hcntNext = '0;
                if (ctrlEn) begin
                    stateNext = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (pwmRise) begin
                    cntNext   = CNT_ONE;
                    stateNext = HIGH_PH;
                end
            end
            HIGH_PH: begin
                if (cnt == CNT_MAX) begin
                    ovfSet    = 1'b1;
                    cntNext   = '0;
                    stateNext = WAIT_RISE;
                end else begin
                    cntNext = cnt + 1'b1;
                    if (pwmFall) begin
                        hcntNext  = cnt;
                        stateNext = LOW_PH;
                    end
                end
            end
            LOW_PH: begin
                if (cnt == CNT_MAX) begin
                    ovfSet    = 1'b1;
                    cntNext   = '0;
                    stateNext = WAIT_RISE;
                end else if (pwmRise) begin
                    capture   = 1'b1;
                    cntNext   = CNT_ONE;
                    stateNext = HIGH_PH;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (!ctrlEn) begin
            stateNext = IDLE;
            cntNext   = '0;
            hcntNext  = '0;
            capture   = 1'b0;
            ovfSet    = 1'b0;
        end
        // Clear overrides everything, including a capture this cycle
        if (clearReq) begin
            stateNext = enNext ? WAIT_RISE : IDLE;
            cntNext   = '0;
            hcntNext  = '0;
            capture   = 1'b0;
            ovfSet    = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high      <= '0;
            ctrlEn    <= 1'b0;
            statValid <= 1'b0;
            statOvf   <= 1'b0;
            bus.oData <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            hcnt  <= hcntNext;
            if (ctrlWr) begin
                ctrlEn <= bus.iData[CTRL_EN_BIT];
            end
            if (clearReq) begin
                period <= '0;
                high   <= '0;
            end else if (capture) begin
                period <= cnt;
                high   <= hcnt;
            end
            statValid <= !clearReq
                         && (capture || (statValid && !w1cValid));
            statOvf   <= !clearReq
                         && (ovfSet || (statOvf && !w1cOvf));
            if (rdEn) begin
                bus.oData <= rdData;
            end
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            ctrlIrqEn <= 1'b0;
            oIrq      <= 1'b0;
        end else begin
            if (ctrlWr) begin
                ctrlIrqEn <= bus.iData[CTRL_IRQ_BIT];
            end
            oIrq <= ctrlIrqEn && (statValid || statOvf);
        end
    end
`else
    assign ctrlIrqEn = 1'b0;
`endif

    always_comb begin
        rdData = '0;
        unique case (bus.iAddress)
            ADDR_CTRL: begin
                rdData[CTRL_EN_BIT]  = ctrlEn;
                rdData[CTRL_IRQ_BIT] = ctrlIrqEn;
            end
            ADDR_STATUS: begin
                rdData[STAT_VALID_BIT] = statValid;
                rdData[STAT_OVF_BIT]   = statOvf;
                rdData[STAT_LEVEL_BIT] = pwmLevel;
            end
            ADDR_PERIOD: rdData = 32'(period);
            ADDR_HIGH:   rdData = 32'(high);
            default:     rdData = '0;
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture built with CNT_W=8 so saturation is reachable.
// Reads push expectations; a negedge monitor pops and compares oData.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int CNT_W = 8;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } rdExp_t;

    logic iClk     = 1'b0;
    logic iReset_n = 1'b0;
    logic iPwm;
    logic genPwm   = 1'b0;
    logic manPwm   = 1'b0;
    logic useGen   = 1'b0;
    logic pwmRun   = 1'b0;
    logic pwmIdle  = 1'b1;
    int   pwmHi    = 10;
    int   pwmLo    = 30;

    int testsRun    = 0;
    int testsFailed = 0;

    rdExp_t      expQ[$];
    rdExp_t      cur;
    logic        rdSeen = 1'b0;
    logic        chkReq = 1'b0;
    logic        chkIrq = 1'b0;
    string       chkName;
    logic [31:0] chkGot;
    logic [31:0] chkExp;
    logic [31:0] chkAct;

`ifdef PWM_CAPTURE_IRQ_EN
    logic oIrq;
`endif

    pwm_capture_if bus();

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .bus      (bus),
        .iPwm     (iPwm)
`ifdef PWM_CAPTURE_IRQ_EN
        ,
        .oIrq     (oIrq)
`endif
    );

    assign iPwm = useGen ? genPwm : manPwm;

    always #5 iClk = ~iClk;

    always @(posedge iClk) begin
        rdSeen <= !bus.iChipselect_n && !bus.iRead_n && bus.iWrite_n;
    end

    always @(negedge iClk) begin
        if (rdSeen) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("FAIL unexpected_read: got %h, required no read",
                         bus.oData);
            end else begin
                cur = expQ.pop_front();
                if ((bus.oData & cur.mask) !== (cur.exp & cur.mask)) begin
                    testsFailed++;
                    $display("FAIL %s: got %h, required %h (mask %h)",
                             cur.name, bus.oData, cur.exp, cur.mask);
                end
            end
        end
        if (chkReq) begin
            chkAct = chkGot;
            if (chkIrq) begin
`ifdef PWM_CAPTURE_IRQ_EN
                chkAct = {31'b0, oIrq};
`endif
            end
            testsRun++;
            if (chkAct !== chkExp) begin
                testsFailed++;
                $display("FAIL %s: got %h, required %h",
                         chkName, chkAct, chkExp);
            end
        end
    end

    // Free-running PWM source; period settings take effect at a rise
    initial begin
        int hi;
        int lo;
        forever begin
            if (pwmRun) begin
                pwmIdle = 1'b0;
                hi = pwmHi;
                lo = pwmLo;
                genPwm = 1'b1;
                repeat (hi) @(posedge iClk);
                #2;
                genPwm = 1'b0;
                repeat (lo) @(posedge iClk);
                #2;
            end else begin
                pwmIdle = 1'b1;
                @(posedge iClk);
                #2;
            end
        end
    end

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        @(posedge iClk);
        #1;
        bus.iChipselect_n = 1'b0;
        bus.iWrite_n      = 1'b0;
        bus.iAddress      = a;
        bus.iData         = d;
        @(posedge iClk);
        #1;
        bus.iChipselect_n = 1'b1;
        bus.iWrite_n      = 1'b1;
    endtask

    task automatic busRead(input logic [1:0]  a,
                           input logic [31:0] e,
                           input logic [31:0] m,
                           input string       nm);
        @(posedge iClk);
        #1;
        bus.iChipselect_n = 1'b0;
        bus.iRead_n       = 1'b0;
        bus.iAddress      = a;
        expQ.push_back('{exp: e, mask: m, name: nm});
        @(posedge iClk);
        #1;
        bus.iChipselect_n = 1'b1;
        bus.iRead_n       = 1'b1;
    endtask

    task automatic postCheck(input string       nm,
                             input logic [31:0] got,
                             input logic [31:0] e,
                             input logic        irq);
        chkName = nm;
        chkGot  = got;
        chkExp  = e;
        chkIrq  = irq;
        chkReq  = 1'b1;
        @(negedge iClk);
        #1;
        chkReq  = 1'b0;
    endtask

    task automatic pinSet(input logic v);
        @(posedge iClk);
        #2;
        manPwm = v;
    endtask

    localparam logic [31:0] ALL   = 32'hFFFF_FFFF;
    localparam logic [31:0] NOLVL = 32'hFFFF_FFFB;

    initial begin
        bus.iChipselect_n = 1'b1;
        bus.iWrite_n      = 1'b1;
        bus.iRead_n       = 1'b1;
        bus.iAddress      = 2'd0;
        bus.iData         = 32'd0;
        repeat (3) @(posedge iClk);
        #1;
        iReset_n = 1'b1;

        busRead(ADDR_CTRL,   32'h0, ALL, "rst_ctrl");
        busRead(ADDR_STATUS, 32'h0, ALL, "rst_status");
        busRead(ADDR_PERIOD, 32'h0, ALL, "rst_period");
        busRead(ADDR_HIGH,   32'h0, ALL, "rst_high");
`ifdef PWM_CAPTURE_IRQ_EN
        postCheck("rst_irq", 32'h0, 32'h0, 1'b1);
`endif

        // 10 high / 30 low
        busWrite(ADDR_CTRL, 32'h1);
        useGen = 1'b1;
        pwmRun = 1'b1;
        repeat (150) @(posedge iClk);
        busRead(ADDR_STATUS, 32'h1,  NOLVL, "run_status");
        busRead(ADDR_PERIOD, 32'd40, ALL,   "run_period");
        busRead(ADDR_HIGH,   32'd10, ALL,   "run_high");
        busRead(ADDR_CTRL,   32'h1,  ALL,   "run_ctrl");

        // 1 high / 3 low
        pwmHi = 1;
        pwmLo = 3;
        repeat (100) @(posedge iClk);
        busRead(ADDR_PERIOD, 32'd4, ALL, "fast_period");
        busRead(ADDR_HIGH,   32'd1, ALL, "fast_high");

        // Disable mid-stream: results and status retained
        busWrite(ADDR_CTRL, 32'h0);
        pwmRun = 1'b0;
        for (int i = 0; i < 200 && !pwmIdle; i++) begin
            @(posedge iClk);
        end
        postCheck("gen_stop", {31'b0, pwmIdle}, 32'h1, 1'b0);
        manPwm = 1'b0;
        useGen = 1'b0;
        busRead(ADDR_PERIOD, 32'd4, ALL,   "dis_period");
        busRead(ADDR_STATUS, 32'h1, NOLVL, "dis_status");
        busWrite(ADDR_CTRL, 32'h1);
        repeat (4) @(posedge iClk);

        // Held high after an arming rise: saturates at 255
        pinSet(1'b1);
        repeat (200) @(posedge iClk);
        busRead(ADDR_STATUS, 32'h5, ALL, "pre_ovf_status");
        repeat (60) @(posedge iClk);
        busRead(ADDR_STATUS, 32'h7, ALL, "ovf_status");
        busRead(ADDR_PERIOD, 32'd4, ALL, "ovf_period");
        busWrite(ADDR_STATUS, 32'h2);
        busRead(ADDR_STATUS, 32'h5, ALL, "ovf_w1c");

        // W1C of valid on the capture edge: set wins
        pinSet(1'b0);
        repeat (4) @(posedge iClk);
        pinSet(1'b1);
        repeat (4) @(posedge iClk);
        pinSet(1'b0);
        repeat (6) @(posedge iClk);
        pinSet(1'b1);
        @(posedge iClk);
        busWrite(ADDR_STATUS, 32'h1);
        busRead(ADDR_STATUS, 32'h5,  ALL, "race_w1c_status");
        busRead(ADDR_PERIOD, 32'd12, ALL, "race_w1c_period");
        busRead(ADDR_HIGH,   32'd5,  ALL, "race_w1c_high");

        // CTRL.clear on the capture edge: clear wins
        pinSet(1'b0);
        repeat (6) @(posedge iClk);
        pinSet(1'b1);
        @(posedge iClk);
        busWrite(ADDR_CTRL, 32'h3);
        busRead(ADDR_PERIOD, 32'h0, ALL, "race_clr_period");
        busRead(ADDR_HIGH,   32'h0, ALL, "race_clr_high");
        busRead(ADDR_STATUS, 32'h4, ALL, "race_clr_status");
        busRead(ADDR_CTRL,   32'h1, ALL, "race_clr_ctrl");

        busWrite(ADDR_CTRL, 32'h5);
`ifdef PWM_CAPTURE_IRQ_EN
        busRead(ADDR_CTRL, 32'h5, ALL, "ctrl_irq_bit");
        pinSet(1'b0);
        repeat (3) @(posedge iClk);
        pinSet(1'b1);
        repeat (3) @(posedge iClk);
        pinSet(1'b0);
        repeat (3) @(posedge iClk);
        pinSet(1'b1);
        repeat (3) @(posedge iClk);
        postCheck("irq_lag", 32'h0, 32'h0, 1'b1);
        @(posedge iClk);
        postCheck("irq_set", 32'h0, 32'h1, 1'b1);
        busRead(ADDR_STATUS, 32'h5, ALL, "irq_status");
        busWrite(ADDR_STATUS, 32'h3);
        postCheck("irq_hold", 32'h0, 32'h1, 1'b1);
        @(posedge iClk);
        postCheck("irq_drop", 32'h0, 32'h0, 1'b1);
`else
        busRead(ADDR_CTRL, 32'h1, ALL, "ctrl_irq_bit");
`endif

        repeat (4) @(posedge iClk);
        postCheck("queue_drained", 32'(expQ.size()), 32'h0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
